// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin arbiter for two masters onto one shared data bus, with ack timeout.
module dbus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req_i,
    input  logic            m1_req_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m0_wdata_i,
    input  logic [DW-1:0]   m1_wdata_i,
    input  logic            m0_we_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic            m0_ack_o,
    output logic            m1_ack_o,
    output logic            m0_err_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m_rdata_o,
    output logic            bus_req_o,
    output logic [AW-1:0]   bus_addr_o,
    output logic [DW-1:0]   bus_wdata_o,
    output logic            bus_we_o,
    output logic [DW/8-1:0] bus_sel_o,
    input  logic            bus_ack_i,
    input  logic [DW-1:0]   bus_rdata_i
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic          last_grant;
    logic          gnt;
    logic          pick;
    logic [CW-1:0] cnt;

    // On a tie the master that was not served last wins
    assign pick = (m0_req_i & m1_req_i) ? ~last_grant : m1_req_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            gnt         <= 1'b0;
            cnt         <= '0;
            m0_ack_o    <= 1'b0;
            m1_ack_o    <= 1'b0;
            m0_err_o    <= 1'b0;
            m1_err_o    <= 1'b0;
            m_rdata_o   <= '0;
            bus_req_o   <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
        end else begin
            case (state)
                IDLE: if (m0_req_i | m1_req_i) begin
                    gnt         <= pick;
                    bus_addr_o  <= pick ? m1_addr_i : m0_addr_i;
                    bus_wdata_o <= pick ? m1_wdata_i : m0_wdata_i;
                    bus_we_o    <= pick ? m1_we_i : m0_we_i;
                    bus_sel_o   <= pick ? m1_sel_i : m0_sel_i;
                    bus_req_o   <= 1'b1;
                    cnt         <= '0;
                    state       <= BUSY;
                end
                BUSY: if (bus_ack_i || cnt == CMAX) begin
                    m_rdata_o <= bus_ack_i ? bus_rdata_i : '0;
                    m0_ack_o  <= ~gnt;
                    m1_ack_o  <= gnt;
                    m0_err_o  <= ~gnt & ~bus_ack_i;
                    m1_err_o  <= gnt & ~bus_ack_i;
                    bus_req_o <= 1'b0;
                    state     <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: begin
                    m0_ack_o   <= 1'b0;
                    m1_ack_o   <= 1'b0;
                    m0_err_o   <= 1'b0;
                    m1_err_o   <= 1'b0;
                    last_grant <= gnt;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning the address width.
REQ-002 SHALL have parameter DW, default 32, meaning the data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the maximum number of cycles to wait for bus_ack_i (legal range 2..65535).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports m0_req_i and m1_req_i, inputs, 1 bit each: request from master 0 (core LSU) and master 1 (DMA/debug).
REQ-007 SHALL have ports m0_addr_i and m1_addr_i, inputs, AW bits each: request address.
REQ-008 SHALL have ports m0_wdata_i and m1_wdata_i, inputs, DW bits each: write data.
REQ-009 SHALL have ports m0_we_i and m1_we_i, inputs, 1 bit each: 1 = write, 0 = read.
REQ-010 SHALL have ports m0_sel_i and m1_sel_i, inputs, DW/8 bits each: byte enables.
REQ-011 SHALL have ports m0_ack_o and m1_ack_o, outputs, 1 bit each: one-cycle completion pulse.
REQ-012 SHALL have ports m0_err_o and m1_err_o, outputs, 1 bit each: timeout flag, valid only while the matching ack is high.
REQ-013 SHALL have port m_rdata_o, output, DW bits: read data shared by both masters, valid with either ack.
REQ-014 SHALL have ports bus_req_o (1 bit), bus_addr_o (AW bits), bus_wdata_o (DW bits), bus_we_o (1 bit) and bus_sel_o (DW/8 bits), all outputs: the downstream shared data bus request.
REQ-015 SHALL have port bus_ack_i, input, 1 bit: downstream completion.
REQ-016 SHALL have port bus_rdata_i, input, DW bits: downstream read data, valid with bus_ack_i.

Function
REQ-017 SHALL implement the FSM states IDLE, BUSY and RESP.
REQ-018 IDLE: if any mX_req_i is high, SHALL grant one master, register that master's addr, wdata, we and sel, and move to BUSY.
REQ-019 Arbitration SHALL be round-robin: when both masters request, the grant goes to the master not recorded in last_grant; when only one requests, that master is granted.
REQ-020 BUSY: SHALL drive bus_req_o=1 and the bus_* fields from the registered copy, so the fields are stable for the whole transaction.
REQ-021 BUSY: a wait counter SHALL start at 0 on entry and increment every cycle that bus_ack_i=0.
REQ-022 BUSY with bus_ack_i=1: SHALL capture bus_rdata_i into m_rdata_o, set err=0 and move to RESP.
REQ-023 BUSY with bus_ack_i=0 and counter = TIMEOUT_CYCLES-1: SHALL move to RESP with err=1 and m_rdata_o=0.
REQ-024 RESP: SHALL pulse the granted master's mX_ack_o (and mX_err_o if err) for exactly 1 cycle, drive bus_req_o=0, set last_grant to the served master, and return to IDLE.
REQ-025 Requests SHALL NOT be sampled in RESP; a req still high in the following IDLE cycle counts as a new request.
REQ-026 Latency: req high in IDLE at cycle n SHALL give bus_req_o at n+1; bus_ack_i at cycle k SHALL give mX_ack_o at k+1; the minimum req-to-ack latency is 2 cycles.
REQ-027 A late bus_ack_i arriving in RESP or IDLE (after a timeout) SHALL be ignored and SHALL NOT generate any mX_ack_o.
REQ-028 The ungranted master's ack and err SHALL stay 0; m0_ack_o and m1_ack_o SHALL never be high in the same cycle.
REQ-029 Changes on the granted master's inputs during BUSY SHALL NOT affect the bus_* outputs.
REQ-030 The counter width SHALL be $clog2(TIMEOUT_CYCLES), and the counter SHALL saturate and never wrap.

Reset
REQ-031 rst=1 SHALL force: state IDLE, last_grant=1 (so master 0 wins the first tie), counter=0, and all outputs 0, including bus_req_o, the bus_* fields, acks, errs and m_rdata_o.
REQ-032 rst asserted mid-transaction SHALL abort it: bus_req_o=0 the next cycle and no ack is issued; after rst deasserts, arbitration resumes from IDLE.

Verification
REQ-033 Single read: m0 reads 0x8000_0010; bus_ack_i in the 3rd BUSY cycle with rdata 0xDEAD_BEEF -> m0_ack_o pulses 1 cycle later with m_rdata_o=0xDEAD_BEEF, err=0, m1_ack_o=0.
REQ-034 Tie after reset: m0 and m1 request in the same cycle -> m0 is served first, then m1; both held high for 4 transactions -> grant order 0,1,0,1.
REQ-035 Zero-wait: bus_ack_i=1 in the first BUSY cycle -> mX_ack_o 2 cycles after req; back-to-back held req gives one ack every 3 cycles.
REQ-036 Timeout: TIMEOUT_CYCLES=4, bus_ack_i never high -> bus_req_o high exactly 4 cycles, then m1_ack_o=1 with m1_err_o=1 and m_rdata_o=0; a bus_ack_i 2 cycles later -> no ack.
REQ-037 Stability: m0 write with sel 0xF; m0_addr_i toggled during BUSY -> bus_addr_o unchanged until completion.
REQ-038 Reset mid-BUSY: rst pulsed 1 cycle -> bus_req_o=0 next cycle, no ack; a new m1 request afterwards is served normally.
